// File: rtl/addr_seq_gen.sv
// Load/store address sequencer: decodes single, halfword, branch and block-transfer
// opcodes and issues transfer addresses over a valid/ready handshake, then a writeback.
module addr_seq_gen #(
    parameter int AW   = 32,
    parameter int NREG = 16,
    parameter int IDXW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [AW-1:0]   INA,
    input  logic [AW-1:0]   INB,
    input  logic [31:0]     OPCODE,
    output logic [AW-1:0]   ADDR,
    output logic            ADDR_VALID,
    input  logic            ADDR_READY,
    output logic [IDXW-1:0] REG_IDX,
    output logic            LAST,
    output logic            WB_EN,
    output logic [AW-1:0]   WB_VAL,
    output logic            BUSY
);

    localparam int CW = IDXW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic [NREG-1:0]   list_q, list_d;
    logic              empty_q, empty_d;
    logic              wb_flag_q, wb_flag_d;
    logic [AW-1:0]     wb_pend_q, wb_pend_d;
    logic [AW-1:0]     wb_val_q, wb_val_d;

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    function automatic logic [IDXW-1:0] low_idx(input logic [NREG-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) if (v[i]) r = IDXW'(i);
        return r;
    endfunction

    // Opcode decode producing the first beat and the writeback of a new request
    logic            is_single, is_half, is_branch, is_block;
    logic            p_bit, u_bit, w_bit;
    logic [AW-1:0]   off, ea, span;
    logic [NREG-1:0] list_in;
    logic [CW-1:0]   cnt_in;
    logic [AW-1:0]   start_addr, start_wb_val;
    logic            start_wb_flag, start_empty, start_last;
    logic [NREG-1:0] start_list;
    logic [IDXW-1:0] start_idx;
    logic            unused_opcode;

    assign unused_opcode = ^OPCODE;

    always_comb begin
        is_single = (OPCODE[27:26] == 2'b01);
        is_half   = (OPCODE[27:25] == 3'b000) && OPCODE[7] && OPCODE[4];
        is_branch = (OPCODE[27:25] == 3'b101);
        is_block  = (OPCODE[27:25] == 3'b100);
        p_bit     = OPCODE[24];
        u_bit     = OPCODE[23];
        w_bit     = OPCODE[21];
        off       = '0;
        if (is_single)
            off = OPCODE[25] ? INA : AW'(OPCODE[11:0]);
        else if (is_half)
            off = OPCODE[22] ? AW'({OPCODE[11:8], OPCODE[3:0]}) : INA;
        ea      = u_bit ? INB + off : INB - off;
        list_in = OPCODE[NREG-1:0];
        cnt_in  = popcount(list_in);
        span    = AW'(cnt_in) << 2;

        start_addr    = INB;
        start_wb_flag = 1'b0;
        start_wb_val  = INB;
        start_list    = '0;
        start_empty   = 1'b0;
        start_idx     = '0;
        start_last    = 1'b1;
        if (is_single || is_half) begin
            start_addr    = p_bit ? ea : INB;
            start_wb_flag = !p_bit || w_bit;
            start_wb_val  = ea;
        end else if (is_branch) begin
            start_addr = INB + INA;
        end else if (is_block) begin
            case ({p_bit, u_bit})
                2'b01:   start_addr = INB;
                2'b11:   start_addr = INB + AW'(4);
                2'b00:   start_addr = INB - span + AW'(4);
                default: start_addr = INB - span;
            endcase
            start_wb_flag = w_bit && (cnt_in != '0);
            start_wb_val  = u_bit ? INB + span : INB - span;
            start_list    = list_in;
            start_empty   = (cnt_in == '0);
            start_idx     = low_idx(list_in);
            start_last    = (cnt_in == CW'(1));
        end
    end

    // Block transfers retire the lowest pending register on every accepted beat
    logic            fire;
    logic [NREG-1:0] list_nxt;

    assign fire     = (state_q == S_ISSUE) && !empty_q && ADDR_READY;
    assign list_nxt = list_q & (list_q - NREG'(1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_ISSUE;
            S_ISSUE: if (empty_q || (fire && last_q)) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY       = (state_q != S_IDLE);
        ADDR_VALID = (state_q == S_ISSUE) && !empty_q;
        ADDR       = addr_q;
        REG_IDX    = idx_q;
        LAST       = ADDR_VALID && last_q;
        WB_EN      = (state_q == S_WB) && wb_flag_q;
        WB_VAL     = wb_val_q;
    end

    always_comb begin
        addr_d    = addr_q;
        idx_d     = idx_q;
        last_d    = last_q;
        list_d    = list_q;
        empty_d   = empty_q;
        wb_flag_d = wb_flag_q;
        wb_pend_d = wb_pend_q;
        wb_val_d  = wb_val_q;
        if (state_q == S_IDLE && START) begin
            addr_d    = start_addr;
            idx_d     = start_idx;
            last_d    = start_last;
            list_d    = start_list;
            empty_d   = start_empty;
            wb_flag_d = start_wb_flag;
            wb_pend_d = start_wb_val;
        end else if (fire && !last_q) begin
            addr_d = addr_q + AW'(4);
            list_d = list_nxt;
            idx_d  = low_idx(list_nxt);
            last_d = (popcount(list_nxt) == CW'(1));
        end
        // WB_VAL only changes on entry to the writeback cycle
        if (state_q == S_ISSUE && state_d == S_WB) wb_val_d = wb_pend_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q    <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            list_q    <= '0;
            empty_q   <= 1'b0;
            wb_flag_q <= 1'b0;
            wb_pend_q <= '0;
            wb_val_q  <= '0;
        end else begin
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            list_q    <= list_d;
            empty_q   <= empty_d;
            wb_flag_q <= wb_flag_d;
            wb_pend_q <= wb_pend_d;
            wb_val_q  <= wb_val_d;
        end
    end

endmodule

// File: tb/tb_addr_seq_gen.sv
// Scoreboard bench for addr_seq_gen: a reference model queues expected beats and
// writebacks at request time; a negedge monitor pops and compares them.
module tb_addr_seq_gen;

    logic        CLK = 1'b0;
    logic        RST, START, ADDR_READY;
    logic [31:0] INA, INB, OPCODE;
    logic [31:0] ADDR, WB_VAL;
    logic        ADDR_VALID, LAST, WB_EN, BUSY;
    logic [3:0]  REG_IDX;

    addr_seq_gen #(.AW(32), .NREG(16), .IDXW(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .INA(INA), .INB(INB), .OPCODE(OPCODE),
        .ADDR(ADDR), .ADDR_VALID(ADDR_VALID), .ADDR_READY(ADDR_READY), .REG_IDX(REG_IDX),
        .LAST(LAST), .WB_EN(WB_EN), .WB_VAL(WB_VAL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] wb_q[$];

    // Reference model of one request
    task automatic model_push(input logic [31:0] op, input logic [31:0] ina, input logic [31:0] inb);
        logic        p, u, w;
        logic [31:0] off, ea, a;
        int          n, seen;
        p = op[24];
        u = op[23];
        w = op[21];
        if (op[27:26] == 2'b01 || (op[27:25] == 3'b000 && op[7] && op[4])) begin
            if (op[27:26] == 2'b01) off = op[25] ? ina : {20'h0, op[11:0]};
            else                    off = op[22] ? ina & 32'h0 | {24'h0, op[11:8], op[3:0]} : ina;
            ea = u ? inb + off : inb - off;
            beat_q.push_back('{p ? ea : inb, 4'd0, 1'b1});
            if (!p || w) wb_q.push_back(ea);
        end else if (op[27:25] == 3'b101) begin
            beat_q.push_back('{inb + ina, 4'd0, 1'b1});
        end else if (op[27:25] == 3'b100) begin
            n = $countones(op[15:0]);
            if (u) a = inb + (p ? 32'd4 : 32'd0);
            else   a = inb - 32'(4 * n) + (p ? 32'd0 : 32'd4);
            seen = 0;
            for (int i = 0; i < 16; i++) begin
                if (op[i]) begin
                    seen++;
                    beat_q.push_back('{a, 4'(i), seen == n});
                    a = a + 32'd4;
                end
            end
            if (w && n > 0) wb_q.push_back(u ? inb + 32'(4 * n) : inb - 32'(4 * n));
        end else begin
            beat_q.push_back('{inb, 4'd0, 1'b1});
        end
    endtask

    // Monitor: scoreboard compare plus stability of a stalled beat
    logic  prev_stall = 1'b0;
    beat_t prev_b;
    beat_t mb;
    logic [31:0] mw;

    always @(negedge CLK) begin
        if (RST) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", ADDR_VALID, 1);
                check("hold_addr", ADDR, prev_b.addr);
                check("hold_idx", REG_IDX, prev_b.idx);
                check("hold_last", LAST, prev_b.last);
            end
            if (ADDR_VALID && ADDR_READY) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", ADDR_VALID, 0);
                end else begin
                    mb = beat_q.pop_front();
                    check("addr", ADDR, mb.addr);
                    check("reg_idx", REG_IDX, mb.idx);
                    check("last", LAST, mb.last);
                end
            end
            if (WB_EN) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", WB_EN, 0);
                end else begin
                    mw = wb_q.pop_front();
                    check("wb_val", WB_VAL, mw);
                end
            end
            prev_stall <= ADDR_VALID && !ADDR_READY;
            prev_b     <= '{ADDR, REG_IDX, LAST};
        end
    end

    task automatic run_req(input logic [31:0] op, input logic [31:0] ina, input logic [31:0] inb,
                           input int stall, input bit poke_start);
        int          nb0, w0, nbeats, cnt, guard;
        bit          has_wb;
        logic [31:0] wb_exp;
        nb0 = beat_q.size();
        w0  = wb_q.size();
        model_push(op, ina, inb);
        nbeats = beat_q.size() - nb0;
        has_wb = wb_q.size() > w0;
        wb_exp = has_wb ? wb_q[$] : 32'h0;
        $display("req op=%h ina=%h inb=%h stall=%0d beats=%0d wb=%0d", op, ina, inb, stall, nbeats, has_wb);
        START = 1'b1; OPCODE = op; INA = ina; INB = inb; ADDR_READY = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0; OPCODE = $urandom; INA = $urandom; INB = $urandom;
        check("busy_start", BUSY, 1);
        check("valid_latency", ADDR_VALID, nbeats > 0);
        cnt = 0;
        guard = 0;
        while (BUSY && guard < 300) begin
            if (poke_start) begin
                START  = (guard == 2);
                OPCODE = 32'hE5B10004;
            end
            if (ADDR_VALID) begin
                if (cnt >= stall) begin ADDR_READY = 1'b1; cnt = 0; end
                else begin ADDR_READY = 1'b0; cnt++; end
            end
            @(posedge CLK); #1;
            guard++;
        end
        START = 1'b0;
        ADDR_READY = 1'b0;
        check("done", BUSY, 0);
        check("beats_left", beat_q.size(), 0);
        check("wb_left", wb_q.size(), 0);
        @(posedge CLK); #1;
        check("idle", BUSY, 0);
        if (has_wb) check("wb_hold", WB_VAL, wb_exp);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_addr"}, ADDR, 0);
        check({tag, "_valid"}, ADDR_VALID, 0);
        check({tag, "_idx"}, REG_IDX, 0);
        check({tag, "_last"}, LAST, 0);
        check({tag, "_wb_en"}, WB_EN, 0);
        check({tag, "_wb_val"}, WB_VAL, 0);
        check({tag, "_busy"}, BUSY, 0);
    endtask

    logic [31:0] op_tab [0:10];

    initial begin
        logic [31:0] op;
        op_tab[0] = 32'hE5B10004; op_tab[1] = 32'hE6010002; op_tab[2]  = 32'hE8B00085;
        op_tab[3] = 32'hE92D000F; op_tab[4] = 32'hE1F010B4; op_tab[5]  = 32'hE01010B0;
        op_tab[6] = 32'hEA000000; op_tab[7] = 32'hE0812003; op_tab[8]  = 32'hE8300006;
        op_tab[9] = 32'hE9B00003; op_tab[10] = 32'hE4110010;

        RST = 1'b1; START = 1'b0; ADDR_READY = 1'b0; INA = '0; INB = '0; OPCODE = '0;
        repeat (3) @(posedge CLK);
        #1;
        reset_outputs("reset");
        RST = 1'b0;
        @(posedge CLK); #1;

        run_req(32'hE5B10004, 32'h0,  32'h1000, 0, 0);     // LDR pre, writeback
        run_req(32'hE6010002, 32'h8,  32'h100,  0, 0);     // STR post, reg offset, subtract
        run_req(32'hE8B00085, 32'h0,  32'h2000, 0, 0);     // LDMIA!
        run_req(32'hE92D000F, 32'h0,  32'h100,  3, 1);     // STMDB! stalled, START while busy
        run_req(32'hE59F0FFF, 32'h0,  32'hFFFFFFF8, 0, 0); // address wrap
        run_req(32'hE8B00000, 32'h0,  32'h300,  0, 0);     // empty list
        run_req(32'hE1F010B4, 32'h0,  32'h3000, 1, 0);     // halfword imm pre
        run_req(32'hE01010B0, 32'h10, 32'h50,   0, 0);     // halfword reg post
        run_req(32'hEA000000, 32'h20, 32'h1000, 0, 0);     // branch
        run_req(32'hE0812003, 32'h5,  32'h777,  0, 0);     // other opcode
        run_req(32'hE8300006, 32'h0,  32'h40,   0, 0);     // LDMDA!
        run_req(32'hE9B00003, 32'h0,  32'h10,   2, 0);     // LDMIB!
        run_req(32'hE4110010, 32'h0,  32'h8,    0, 0);     // writeback wrap

        // Reset in the middle of a block transfer aborts with no writeback
        model_push(32'hE8B0FFFF, 32'h0, 32'h500);
        $display("req op=E8B0FFFF inb=00000500 aborted by reset");
        START = 1'b1; OPCODE = 32'hE8B0FFFF; INB = 32'h500; ADDR_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        beat_q.delete();
        wb_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        ADDR_READY = 1'b0;
        reset_outputs("abort");
        repeat (4) @(posedge CLK);
        #1;
        check("abort_busy", BUSY, 0);

        for (int k = 0; k < 16; k++) begin
            op = op_tab[$urandom_range(0, 10)];
            if (op[27:25] == 3'b100) op[15:0] = 16'($urandom_range(0, 65535));
            run_req(op, $urandom, $urandom, $urandom_range(0, 2), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
